// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, memory range bounds, FSM encoding and buffer entry record
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_LO = 32'h0000_3000;
  localparam logic [31:0] IM_HI = 32'h0000_6FFF;
  typedef enum logic {RUN = 1'b0, FAULT_HOLD = 1'b1} state_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic fault;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two instruction buffer with flush; empty head reads as zero
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 65
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic do_pop, do_push;
  assign valid = count != '0;
  assign do_pop = pop && valid;
  assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
  assign dout = valid ? mem[head] : '0;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop) head <= head + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk)
    if (do_push && !flush && !reset) mem[tail] <= din;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequential fetch with redirect/exception flush; FETCH_ADDR_CHECK_EN enables address faults
module fetch_ctrl import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_pc,
  input  logic [31:0] im_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_valid,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        dec_fault
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_nxt;
  logic [31:0] fetch_pc, pc_nxt;
  logic [CW-1:0] count;
  logic flush, pop, push, fault;
  entry_t wr, rd;
  assign im_pc = fetch_pc;
  assign flush = exc_valid || redirect_valid;
  assign pop = dec_valid && dec_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      fetch_pc <= pc_nxt;
    end
  end
  always_comb begin
    state_nxt = flush ? RUN : (push && fault) ? FAULT_HOLD : state;
    pc_nxt = exc_valid ? HANDLER_PC : redirect_valid ? redirect_pc : push ? fetch_pc + 32'd4 : fetch_pc;
  end
  always_comb begin
`ifdef FETCH_ADDR_CHECK_EN
    fault = (fetch_pc[1:0] != 2'b00) || (fetch_pc < IM_LO) || (fetch_pc > IM_HI);
`else
    fault = 1'b0;
`endif
    push = state == RUN && !flush && (count != CW'(DEPTH) || pop);
    wr = '{inst: fault ? 32'd0 : im_inst, pc: fetch_pc, fault: fault};
  end
  fetch_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk(clk), .reset(reset), .flush(flush), .push(push), .pop(pop),
    .din(wr), .dout(rd), .valid(dec_valid), .count(count)
  );
  assign dec_inst = rd.inst;
  assign dec_pc = rd.pc;
`ifdef FETCH_ADDR_CHECK_EN
  assign dec_fault = rd.fault;
`else
  assign dec_fault = 1'b0 & rd.fault;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch sequencing, stall, flush, priority, reset and faults
module tb_fetch_ctrl;
  logic clk = 0, reset = 1;
  logic [31:0] im_pc, im_inst, redirect_pc = 0, dec_inst, dec_pc;
  logic redirect_valid = 0, exc_valid = 0, dec_valid, dec_ready = 0, dec_fault;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hBEEF, pc[15:0]};
  endfunction
  assign im_inst = inst_of(im_pc);
  fetch_ctrl dut (
    .clk(clk), .reset(reset), .im_pc(im_pc), .im_inst(im_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exc_valid(exc_valid),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .dec_fault(dec_fault)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, dec_valid}, 32'd1);
    check({tag, "_pc"}, dec_pc, pc);
    check({tag, "_inst"}, dec_inst, inst_of(pc));
    check({tag, "_fault"}, {31'd0, dec_fault}, 32'd0);
  endtask
  initial begin
    step();
    step();
    check("rst_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_im_pc", im_pc, 32'h3000);
    check("rst_dec_pc", dec_pc, 32'd0);
    check("rst_dec_inst", dec_inst, 32'd0);
    check("rst_fault", {31'd0, dec_fault}, 32'd0);
    reset = 0;
    dec_ready = 1;
    step(); head("seq0", 32'h3000);
    step(); head("seq1", 32'h3004);
    step(); head("seq2", 32'h3008);
    reset = 1;
    step();
    reset = 0;
    dec_ready = 0;
    repeat (5) step();
    check("stall_im_pc", im_pc, 32'h3008);
    head("stall_head", 32'h3000);
    dec_ready = 1;
    step(); head("rel0", 32'h3004);
    step(); head("rel1", 32'h3008);
    step(); head("rel2", 32'h300C);
    dec_ready = 0;
    step();
    check("full_im_pc", im_pc, 32'h3014);
    redirect_valid = 1;
    redirect_pc = 32'h3100;
    dec_ready = 1;
    step();
    check("redir_valid", {31'd0, dec_valid}, 32'd0);
    check("redir_im_pc", im_pc, 32'h3100);
    redirect_valid = 0;
    step(); head("redir0", 32'h3100);
    step(); head("redir1", 32'h3104);
    exc_valid = 1;
    redirect_valid = 1;
    redirect_pc = 32'h3200;
    step();
    check("exc_valid_low", {31'd0, dec_valid}, 32'd0);
    check("exc_im_pc", im_pc, 32'h4180);
    exc_valid = 0;
    redirect_valid = 0;
    dec_ready = 0;
    step(); head("exc0", 32'h4180);
    step(); head("exc_hold", 32'h4180);
    reset = 1;
    step();
    check("midrst_valid", {31'd0, dec_valid}, 32'd0);
    reset = 0;
    dec_ready = 1;
    step(); head("restart", 32'h3000);
`ifdef FETCH_ADDR_CHECK_EN
    redirect_valid = 1;
    redirect_pc = 32'h3002;
    step();
    redirect_valid = 0;
    step();
    check("flt_valid", {31'd0, dec_valid}, 32'd1);
    check("flt_fault", {31'd0, dec_fault}, 32'd1);
    check("flt_pc", dec_pc, 32'h3002);
    check("flt_inst", dec_inst, 32'd0);
    step();
    step();
    check("flt_halt_valid", {31'd0, dec_valid}, 32'd0);
    check("flt_halt_im_pc", im_pc, 32'h3006);
    exc_valid = 1;
    step();
    exc_valid = 0;
    step(); head("flt_exc", 32'h4180);
`else
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0;
    step();
    head("wrap", 32'hFFFF_FFFC);
    check("wrap_im_pc", im_pc, 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter HANDLER_PC, default 32'h0000_4180, exception-handler entry address.
REQ-003 Parameter DEPTH, default 2, instruction-buffer entries (power of two, 2..8).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 im_pc  out  32  address driven to the combinational instruction memory; equals fetch_pc.
REQ-007 im_inst  in  32  instruction word returned by instruction memory for im_pc in the same cycle.
REQ-008 redirect_valid  in  1  branch/jump/eret redirect request.
REQ-009 redirect_pc  in  32  redirect target.
REQ-010 exc_valid  in  1  exception request; target is HANDLER_PC.
REQ-011 dec_valid  out  1  buffer head holds a valid entry.
REQ-012 dec_ready  in  1  decode accepts head entry this cycle.
REQ-013 dec_inst  out  32  head instruction.
REQ-014 dec_pc  out  32  head instruction address.
REQ-015 dec_fault  out  1  head entry carries a fetch address fault.

Function
REQ-016 fetch_pc register SHALL hold the next fetch address; im_pc SHALL equal fetch_pc combinationally.
REQ-017 FIFO of DEPTH entries {inst, pc, fault}; pop when dec_valid && dec_ready; head presented combinationally from storage.
REQ-018 Push SHALL occur when state is RUN, no exc_valid, no redirect_valid, and (count < DEPTH or pop this cycle); push writes {im_inst, fetch_pc, fault} and advances fetch_pc by 4.
REQ-019 Simultaneous push and pop when full SHALL leave count unchanged; pop from empty SHALL never occur (dec_valid low).
REQ-020 Priority per cycle: reset > exc_valid > redirect_valid > sequential fetch.
REQ-021 exc_valid SHALL flush FIFO (count 0), set fetch_pc = HANDLER_PC, state RUN, no push that cycle; redirect_valid alone does the same with redirect_pc.
REQ-022 Flush cycle: dec_valid low the following cycle; first redirected instruction valid two cycles after the redirect cycle edge; a same-cycle pop is discarded harmlessly.
REQ-023 States: RUN (fetching), FAULT_HOLD (fetch stopped after pushing a faulted entry); RUN->FAULT_HOLD on push of fault=1; FAULT_HOLD->RUN only on exc_valid or redirect_valid.
REQ-024 fetch_pc addition SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-025 Latency: first instruction after reset release valid on dec_valid the cycle after the first RUN edge (1-cycle fetch-to-decode).

Reset
REQ-026 On reset: fetch_pc = RESET_PC, count 0, head/tail pointers 0, state RUN, dec_valid 0, dec_inst/dec_pc 0 when empty-masked, dec_fault 0.
REQ-027 Reset mid-operation SHALL discard all buffered entries and pending redirects without emitting any.

Configuration
REQ-028 Macro FETCH_ADDR_CHECK_EN defined: fault = 1 when fetch_pc[1:0] != 0 or fetch_pc outside [32'h0000_3000, 32'h0000_6FFF]; faulted entry's inst forced to 0.
REQ-029 Macro undefined: fault always 0, dec_fault tied 0, FAULT_HOLD unreachable, no range comparators synthesized.

Structure
REQ-030 Shared package fetch_pkg SHALL hold RESET_PC/HANDLER_PC defaults, IM range bounds (32'h3000, 32'h6FFF), state encoding and entry-record typedef.
REQ-031 One sub-module fetch_fifo (parameterized depth/width, push/pop/flush, count) SHALL implement the buffer; FSM and PC logic stay in fetch_ctrl.

Verification
REQ-032 Reset, dec_ready=1 held -> dec_pc sequence 0x3000, 0x3004, 0x3008 on consecutive cycles, dec_inst matches memory.
REQ-033 dec_ready=0 for 5 cycles -> count saturates at DEPTH, fetch_pc stops at 0x3000+4*DEPTH, no entry lost or duplicated on release.
REQ-034 redirect_valid with redirect_pc=0x3100 while buffer full -> flush, next dec_pc=0x3100, no stale entries delivered.
REQ-035 exc_valid and redirect_valid same cycle -> next dec_pc = 0x4180.
REQ-036 FETCH_ADDR_CHECK_EN, redirect_pc=0x3002 -> dec_fault=1, dec_pc=0x3002, dec_inst=0, fetching halts until exc_valid, then dec_pc=0x4180.
REQ-037 reset asserted with 2 entries buffered -> dec_valid 0 next cycle, then dec_pc restarts at 0x3000.
